data_memory_mp: RTL

//  Multi-channel, byte-writable synchronous data memory for the GPP tx/rx tile. Serves NUM_CH

---
 rtl/data_memory_mp_pkg.sv | 25 ++
 rtl/data_memory_mp_rr_arbiter.sv | 45 ++++
 rtl/data_memory_mp.sv | 94 +++++++++
 3 files changed

// File: rtl/data_memory_mp_pkg.sv
// Shared sizing constants and a byte-lane merge helper for the multi-channel data memory.
package data_memory_pkg;

   localparam int DM_ADDR_WIDTH = 8;
   localparam int DM_DATA_WIDTH = 32;
   localparam int DM_NUM_CH     = 2;
   localparam int DM_BYTES      = DM_DATA_WIDTH / 8;

   // Returns old_word with every byte lane whose strobe is set replaced by new_word's lane.
   function automatic logic [DM_DATA_WIDTH-1:0] byte_merge(
      input logic [DM_DATA_WIDTH-1:0] old_word,
      input logic [DM_DATA_WIDTH-1:0] new_word,
      input logic [DM_BYTES-1:0]      be
   );
      logic [DM_DATA_WIDTH-1:0] merged;
      merged = old_word;
      for (int b = 0; b < DM_BYTES; b++) begin
         if (be[b]) begin
            merged[b*8 +: 8] = new_word[b*8 +: 8];
         end
      end
      return merged;
   endfunction

endpackage

// File: rtl/data_memory_mp_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after the priority pointer.
// The pointer moves just past the winner only when the caller reports a completed transfer.
module rr_arbiter #(
   parameter int N = 2
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic [N-1:0] req,
   input  logic         advance,
   output logic [N-1:0] grant
);

   localparam int PW = (N > 1) ? $clog2(N) : 1;

   logic [PW-1:0] ptr_reg;
   logic [PW-1:0] ptr_next;
   logic [PW-1:0] idx;
   logic          found;

   // Scan ptr, ptr+1, ... with wrap; the first asserted request wins and sets the next pointer.
   always_comb begin
      grant    = '0;
      ptr_next = ptr_reg;
      idx      = '0;
      found    = 1'b0;
      for (int i = 0; i < N; i++) begin
         idx = PW'((int'(ptr_reg) + i) % N);
         if (!found && req[idx]) begin
            found      = 1'b1;
            grant[idx] = 1'b1;
            ptr_next   = PW'((int'(idx) + 1) % N);
         end
      end
   end

   // Priority pointer: channel 0 first out of reset, holds when nothing transfers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ptr_reg <= '0;
      end else if (advance) begin
         ptr_reg <= ptr_next;
      end
   end

endmodule

// File: rtl/data_memory_mp.sv
// Multi-channel byte-writable data memory: one arbitrated access per cycle, responses one
// cycle after the transfer on the granted channel's resp_valid bit.
module data_memory_mp
   import data_memory_pkg::*;
#(
   parameter int ADDR_WIDTH = DM_ADDR_WIDTH,
   parameter int DATA_WIDTH = DM_DATA_WIDTH,
   parameter int NUM_CH     = DM_NUM_CH
) (
   input  logic                                   clk,
   input  logic                                   reset_n,
   input  logic [NUM_CH-1:0]                      req_valid,
   output logic [NUM_CH-1:0]                      req_ready,
   input  logic [NUM_CH-1:0]                      req_write,
   input  logic [NUM_CH-1:0][ADDR_WIDTH-1:0]      req_address,
   input  logic [NUM_CH-1:0][DATA_WIDTH/8-1:0]    req_byte_enable,
   input  logic [NUM_CH-1:0][DATA_WIDTH-1:0]      req_data_in,
   output logic [NUM_CH-1:0]                      resp_valid,
   output logic [DATA_WIDTH-1:0]                  resp_data_out
);

   localparam int NB    = DATA_WIDTH / 8;
   localparam int DEPTH = 2 ** ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic [NUM_CH-1:0]     grant;
   logic                  transfer;
   logic                  sel_write;
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic [NB-1:0]         sel_be;
   logic [DATA_WIDTH-1:0] sel_data;

   logic [DATA_WIDTH-1:0] rd_data_reg;
   logic [NUM_CH-1:0]     resp_valid_reg;
   logic                  resp_read_reg;

   rr_arbiter #(.N(NUM_CH)) u_arb (
      .clk     (clk),
      .reset_n (reset_n),
      .req     (req_valid),
      .advance (transfer),
      .grant   (grant)
   );

   assign req_ready = grant;
   assign transfer  = |(req_valid & grant);

   // Route the granted channel's request fields to the single memory port.
   always_comb begin
      sel_write = 1'b0;
      sel_addr  = '0;
      sel_be    = '0;
      sel_data  = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (grant[c]) begin
            sel_write = req_write[c];
            sel_addr  = req_address[c];
            sel_be    = req_byte_enable[c];
            sel_data  = req_data_in[c];
         end
      end
   end

   // Memory port: byte-masked write or registered read of the old contents; never cleared.
   always_ff @(posedge clk) begin
      if (transfer) begin
         if (sel_write) begin
            for (int b = 0; b < NB; b++) begin
               if (sel_be[b]) begin
                  mem[sel_addr][b*8 +: 8] <= sel_data[b*8 +: 8];
               end
            end
         end else begin
            rd_data_reg <= mem[sel_addr];
         end
      end
   end

   // Response flags: one-hot pulse for the channel that transferred; dropped on reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         resp_valid_reg <= '0;
         resp_read_reg  <= 1'b0;
      end else begin
         resp_valid_reg <= transfer ? grant : '0;
         resp_read_reg  <= transfer & ~sel_write;
      end
   end

   assign resp_valid    = resp_valid_reg;
   assign resp_data_out = resp_read_reg ? rd_data_reg : '0;

endmodule
